insmem_fetch: RTL and testbench

- Parametrised, synchronous successor to the combinational instruction memory.
- Holds DEPTH words of DATA_W bits and serves fetch requests over a valid/ready handshake with one-cycle read latency and a held response register.
- Has a write-side program-load port for boot and test image loading.
- Flags out-of-range fetches, returning a configurable NOP. Sits between the PC/fetch stage and decode.

---
 rtl/insmem_fetch_if.sv | 38 +++
 rtl/insmem_fetch.sv | 81 ++++++++
 tb/tb_insmem_fetch.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/insmem_fetch_if.sv
// -----------------------------------------------------------------------------
// insmem_fetch_if
// Bundles the program-load port and the fetch request/response handshake of
// the synchronous instruction memory.
//   load_en/load_addr/load_data : program-load write port (driven by loader)
//   req_valid/req_addr          : fetch request (driven by PC/fetch stage)
//   req_ready                   : memory accepts a fetch this cycle
//   rsp_valid/rsp_code/rsp_err  : registered fetch response (to decode)
//   rsp_ready                   : decode takes the response
// The master modport is the PC/fetch/loader side, slave is the memory.
// -----------------------------------------------------------------------------
interface insmem_fetch_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_code;
    logic              rsp_err;

    modport master (
        output load_en, load_addr, load_data,
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_code, rsp_err
    );

    modport slave (
        input  load_en, load_addr, load_data,
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_code, rsp_err
    );
endinterface

// File: rtl/insmem_fetch.sv
// -----------------------------------------------------------------------------
// insmem_fetch
// Synchronous instruction memory with a valid/ready fetch port, one-cycle
// read latency and a held response register. A program-load write port
// fills the array at boot or test time. Fetches beyond DEPTH return NOP_CODE
// with rsp_err set.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (clears the response register only)
//   bus  : insmem_fetch_if slave (load port, fetch request, fetch response)
// -----------------------------------------------------------------------------
module insmem_fetch #(
    parameter int              ADDR_W   = 6,
    parameter int              DATA_W   = 32,
    parameter int              DEPTH    = 64,
    parameter logic [DATA_W-1:0] NOP_CODE = '0
) (
    input  logic           clk,
    input  logic           rst,
    insmem_fetch_if.slave  bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so that DEPTH == 2**ADDR_W is representable as the limit.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              load_in_range;
    logic              req_in_range;
    logic [IDX_W-1:0]  load_idx;
    logic [IDX_W-1:0]  req_idx;
    logic              accept;

    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_code_q;
    logic              rsp_err_q;

    // Bounds checks use the full address width so nothing wraps around;
    // the index slices are only used once the address is known in range.
    assign load_in_range = {1'b0, bus.load_addr} < DEPTH_LIM;
    assign req_in_range  = {1'b0, bus.req_addr} < DEPTH_LIM;
    assign load_idx      = bus.load_addr[IDX_W-1:0];
    assign req_idx       = bus.req_addr[IDX_W-1:0];

    // A load owns the cycle, so fetch and load never coincide and a fetch
    // right after a load always sees the freshly written word. Otherwise a
    // fetch is taken when the response register is empty or being drained.
    assign bus.req_ready = !bus.load_en && (!rsp_valid_q || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    // Program-load writes. The array is deliberately left out of reset so a
    // loaded image survives a reset pulse; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (bus.load_en && load_in_range) begin
            mem[load_idx] <= bus.load_data;
        end
    end

    // Response register. An accept always refills it (also when the current
    // response is popped in the same cycle, giving one fetch per cycle); a pop
    // with no accept only clears the valid flag and keeps the last code/err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_code_q  <= req_in_range ? mem[req_idx] : NOP_CODE;
            rsp_err_q   <= !req_in_range;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_code  = rsp_code_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_insmem_fetch.sv
// -----------------------------------------------------------------------------
// tb_insmem_fetch
// Scoreboard bench for insmem_fetch (DEPTH=40, NOP_CODE=32'h13). Stimulus
// drives one cycle at a time and pushes the expected response whenever the
// reference model says a fetch is accepted; an independent monitor compares
// the registered response every cycle and pops on consumption.
// -----------------------------------------------------------------------------
module tb_insmem_fetch;

    localparam int          ADDR_W = 6;
    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 40;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct {
        logic [31:0] code;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;

    insmem_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    insmem_fetch #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .NOP_CODE (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          pushed = 0;
    int          popped = 0;
    logic        monitor_on = 1'b0;
    exp_t        exp_q[$];
    logic [31:0] model_mem [64];
    logic [31:0] last_code = '0;
    logic        last_err  = 1'b0;

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge, then checks
    // req_ready against the model: a load blocks fetches, and otherwise a
    // fetch is possible once the monitor has drained (or found empty) the
    // single response slot. Accepted fetches push their expected response.
    task automatic applyStimulus(input logic le, input logic [5:0] la,
                                 input logic [31:0] ld, input logic rv,
                                 input logic [5:0] ra, input logic rr);
        logic exp_ready;
        exp_t e;
        @(posedge clk);
        #1;
        bus.load_en   = le;
        bus.load_addr = la;
        bus.load_data = ld;
        bus.req_valid = rv;
        bus.req_addr  = ra;
        bus.rsp_ready = rr;
        #2;
        exp_ready = !le && (exp_q.size() == 0);
        checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        if (rv && exp_ready) begin
            if (int'(ra) < DEPTH) begin
                e.code = model_mem[ra];
                e.err  = 1'b0;
            end else begin
                e.code = NOP;
                e.err  = 1'b1;
            end
            exp_q.push_back(e);
            pushed++;
        end
        if (le && int'(la) < DEPTH) begin
            model_mem[la] = ld;
        end
    endtask

    // Monitor: two time units after each edge, the response register must
    // show the queue head whenever the model holds a pending response, and
    // otherwise keep the last consumed code/err. A set rsp_ready consumes it.
    initial begin
        exp_t h;
        forever begin
            @(posedge clk);
            #2;
            if (monitor_on) begin
                checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    checkOutput("rsp_code", bus.rsp_code, exp_q[0].code);
                    checkOutput("rsp_err", 32'(bus.rsp_err), 32'(exp_q[0].err));
                    if (bus.rsp_ready) begin
                        h = exp_q.pop_front();
                        last_code = h.code;
                        last_err  = h.err;
                        popped++;
                    end
                end else begin
                    checkOutput("rsp_code_hold", bus.rsp_code, last_code);
                    checkOutput("rsp_err_hold", 32'(bus.rsp_err), 32'(last_err));
                end
            end
        end
    end

    // Directed scenarios first, then a randomized phase over the whole
    // address space once every in-range word holds known data.
    initial begin
        rst           = 1'b1;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #3;
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_rsp_code", bus.rsp_code, 32'd0);
        checkOutput("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
        #1;
        rst        = 1'b0;
        monitor_on = 1'b1;

        $display("[TB] load and stream read-back");
        for (int i = 0; i < 22; i++)
            applyStimulus(1'b1, 6'(i), 32'h1000_0000 + 32'(i), 1'b0, 6'd0, 1'b1);
        for (int i = 0; i < 22; i++)
            applyStimulus(1'b0, 6'd0, 32'd0, 1'b1, 6'(i), 1'b1);
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b1);

        $display("[TB] backpressure");
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b1, 6'd3, 1'b1);
        repeat (4) applyStimulus(1'b0, 6'd0, 32'd0, 1'b1, 6'd4, 1'b0);
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b1, 6'd4, 1'b1);
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b1);

        $display("[TB] out-of-range fetch and load");
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b1, 6'd45, 1'b1);
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b1);
        applyStimulus(1'b1, 6'd50, 32'hCAFE_0050, 1'b0, 6'd0, 1'b1);
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b1, 6'd50, 1'b1);
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b1);

        $display("[TB] load priority and read-after-load");
        applyStimulus(1'b1, 6'd5, 32'hDEAD_BEEF, 1'b1, 6'd5, 1'b1);
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b1, 6'd5, 1'b1);
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b1);

        $display("[TB] bubbles");
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 6'd0, 32'd0, (i % 2) == 0, 6'(10 + i), 1'b1);
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b1);

        $display("[TB] async reset mid-response");
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b1, 6'd7, 1'b1);
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("async_rst_code", bus.rsp_code, 32'd0);
        checkOutput("async_rst_err", 32'(bus.rsp_err), 32'd0);
        exp_q.delete();
        pushed    = popped;
        last_code = '0;
        last_err  = 1'b0;
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b1, 6'd7, 1'b1);
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 22; i < DEPTH; i++)
            if (i != 5 && i != 7)
                applyStimulus(1'b1, 6'(i), $urandom, 1'b0, 6'd0, 1'b1);
        for (int n = 0; n < 400; n++)
            applyStimulus($urandom_range(0, 4) == 0, 6'($urandom_range(0, 63)), $urandom,
                          $urandom_range(0, 3) != 0, 6'($urandom_range(0, 63)),
                          $urandom_range(0, 3) != 0);
        repeat (3) applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b1);

        checkOutput("rsp_count", 32'(popped), 32'(pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
